// File: rtl/dp_ram16k_fifo_ctrl.sv
// dp_ram16k_fifo_ctrl: FWFT stream FIFO driving one DP_RAM16K in 512x32 mode.
// Define DP_FIFO_ALMOST_EN to add registered almost_full/almost_empty flags.
module dp_ram16k_fifo_ctrl #(
    parameter int DEPTH = 512
`ifdef DP_FIFO_ALMOST_EN
    ,
    parameter int AF_LEVEL = 480,
    parameter int AE_LEVEL = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [9:0]  count,
    output logic        ram_wen,
    output logic [8:0]  ram_waddr,
    output logic [31:0] ram_d_in,
    output logic [31:0] ram_wenb,
    output logic        ram_ren,
    output logic [8:0]  ram_raddr,
`ifdef DP_FIFO_ALMOST_EN
    output logic        almost_full,
    output logic        almost_empty,
`endif
    input  logic [31:0] ram_d_out
);
    logic [8:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [9:0] ram_cnt_q, ram_cnt_d, count_q, count_d;
    logic       out_valid_q, out_valid_d;
    logic       push, fetch, pop;
    always_comb begin
        s_ready     = ~rst & (count_q < 10'(DEPTH));
        push        = s_valid & s_ready;
        fetch       = (ram_cnt_q != '0) & (~out_valid_q | m_ready) & ~rst;
        m_valid     = out_valid_q & ~rst;
        pop         = m_valid & m_ready;
        wr_ptr_d    = wr_ptr_q + 9'(push);
        rd_ptr_d    = rd_ptr_q + 9'(fetch);
        ram_cnt_d   = ram_cnt_q + 10'(push) - 10'(fetch);
        // a pop that coincides with a fetch keeps the output register occupied
        out_valid_d = fetch | (out_valid_q & ~pop);
        count_d     = ram_cnt_d + 10'(out_valid_d);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            ram_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            count_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ram_cnt_q   <= ram_cnt_d;
            out_valid_q <= out_valid_d;
            count_q     <= count_d;
        end
    end
    assign count     = count_q;
    assign m_data    = ram_d_out;
    assign ram_wen   = ~push;
    assign ram_waddr = wr_ptr_q;
    assign ram_d_in  = s_data;
    assign ram_wenb  = 32'hFFFF_FFFF;
    assign ram_ren   = ~fetch;
    assign ram_raddr = rd_ptr_q;
`ifdef DP_FIFO_ALMOST_EN
    logic almost_full_q, almost_full_d, almost_empty_q, almost_empty_d;
    always_comb begin
        almost_full_d  = count_d >= 10'(AF_LEVEL);
        almost_empty_d = count_d <= 10'(AE_LEVEL);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
        end else begin
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
        end
    end
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
`endif
endmodule

// File: doc/dp_ram16k_fifo_ctrl.md
# dp_ram16k_fifo_ctrl

Synchronous FIFO controller that drives the write and read ports of one DP_RAM16K macro in 512 x 32 mode and presents it as a valid/ready stream FIFO. It generates active-low write and read strobes, write and read addresses, and the write mask, and it absorbs the macro's one-cycle registered read so the output is first-word-fall-through. It sits between fabric stream producers and consumers, with both RAM clocks (`rclk`, `wclk`) tied to `clk`.

## Interface
- `DEPTH`, 512: FIFO capacity in words; fixed by the macro's 9-bit address.
- `AF_LEVEL`, 480: almost-full threshold; used only with `DP_FIFO_ALMOST_EN`.
- `AE_LEVEL`, 32: almost-empty threshold; used only with `DP_FIFO_ALMOST_EN`.

Ports:
- `clk`  in  1  clock; also drives the RAM `rclk` and `wclk`.
- `rst`  in  1  reset; synchronous, active-high.
- `s_valid`  in  1  write-side data valid.
- `s_ready`  out  1  write-side ready; high when count < 512 and `rst` is low.
- `s_data`  in  32  write data.
- `m_valid`  out  1  read-side data valid.
- `m_ready`  in  1  read-side accept.
- `m_data`  out  32  read data; equals `ram_d_out`.
- `count`  out  10  number of words held, 0..512, registered.
- `ram_wen`  out  1  RAM write strobe; active-low.
- `ram_waddr`  out  9  RAM write address.
- `ram_d_in`  out  32  RAM write data; equals `s_data`.
- `ram_wenb`  out  32  RAM write mask; constant 32'hFFFF_FFFF.
- `ram_ren`  out  1  RAM read strobe; active-low.
- `ram_raddr`  out  9  RAM read address.
- `ram_d_out`  in  32  RAM registered read data.
- `almost_full`  out  1  present only with `DP_FIFO_ALMOST_EN`.
- `almost_empty`  out  1  present only with `DP_FIFO_ALMOST_EN`.

## Operation
- **State:**
  - `wr_ptr[8:0]` and `rd_ptr[8:0]` wrap modulo 512.
  - `ram_cnt[9:0]` is the number of words committed in the RAM and not yet fetched.
  - `out_valid` means `ram_d_out` holds an unconsumed word.
  - `count = ram_cnt + out_valid`.
- **Push:** `push = s_valid & s_ready`.
  - `ram_wen = ~push`, `ram_waddr = wr_ptr`.
  - On push, `wr_ptr` increments.
- **Fetch:** `fetch = (ram_cnt != 0) & (~out_valid | m_ready) & ~rst`.
  - `ram_ren = ~fetch`, `ram_raddr = rd_ptr`.
  - On fetch, `rd_ptr` increments and `out_valid` is set next cycle.
- **Pop:** `pop = m_valid & m_ready`.
  - Pop without a same-cycle fetch clears `out_valid`.
  - Pop with a same-cycle fetch keeps `out_valid` = 1 and the new word replaces the old one.
- **Counter update:** `ram_cnt` next = `ram_cnt + push - fetch`.
- **Output:** `m_valid = out_valid`. `m_data` is held stable while `m_valid & ~m_ready`, because the RAM output register only changes on a read strobe.
- **Full:** at count == 512, `s_ready` = 0, even if a pop happens in the same cycle. The freed slot becomes writable the next cycle.
- **Empty:** with `ram_cnt` == 0, no fetch is issued and `ram_ren` stays 1.
- **Same-address hazard:** a word written at edge N is fetched no earlier than cycle N+1. The RAM's read-old-data behaviour on a same-cycle collision is therefore never exercised.
- **Reset:** `rst` high for one or more edges has the following effect.
  - Pointers, `ram_cnt`, `out_valid` and `count` go to 0.
  - During `rst`: `s_ready` = 0, `m_valid` = 0, `ram_wen` = 1, `ram_ren` = 1.
  - RAM contents are not cleared.
  - Reset mid-stream discards all buffered words. `m_valid` is 0 from the first edge with `rst` high.

## Timing
- **Reset values:** `s_ready` 0 during reset and 1 on the first cycle after it; `m_valid` 0; `count` 0; `ram_wen` 1; `ram_ren` 1; `ram_waddr` and `ram_raddr` 0; `almost_full` 0; `almost_empty` 1.
- **Write-to-read latency:** a push at edge N (FIFO empty) gives a fetch in cycle N+1 and `m_valid` = 1 in cycle N+2.
- **Throughput:** 1 word/cycle sustained when both sides are continuously valid and ready.
- **Combinational paths:**
  - `s_ready` and `ram_wen` depend only on registered `count`, `rst` and `s_valid`.
  - `ram_ren` depends combinationally on `m_ready`.
- **`count` update:** changes the edge after push or pop.

## Configuration
- `DP_FIFO_ALMOST_EN` defined:
  - Adds registered `almost_full` = (count >= `AF_LEVEL`) and `almost_empty` = (count <= `AE_LEVEL`).
  - Both flags are evaluated on the next-state count, so they are coincident with `count`.
- `DP_FIFO_ALMOST_EN` undefined: both ports and their logic are absent, and `AF_LEVEL` and `AE_LEVEL` are unused.

## Test plan
- **Single word:** after reset, push 32'hDEAD_BEEF at edge 0.
  - `ram_wen` = 0 with `ram_waddr` = 0 in cycle 0, and `ram_ren` = 0 with `ram_raddr` = 0 in cycle 1.
  - `m_valid` = 1 and `m_data` = 32'hDEAD_BEEF in cycle 2; `count` = 1 from cycle 1.
- **Fill to full:** push 512 words with `m_ready` = 0.
  - `count` = 512 and `s_ready` = 0; a 513th `s_valid` produces no `ram_wen` pulse.
  - One pop then gives `s_ready` = 1 the following cycle.
- **Streaming and wrap:** push 1..1000 back-to-back while `m_ready` = 1.
  - Output sequence is 1..1000, in order, with no gaps after the first word.
  - `wr_ptr` wraps 511→0 without error; `count` never exceeds 2.
- **Backpressure:** fill 4 words, then toggle `m_ready` randomly.
  - `m_data` stays constant while `m_valid & ~m_ready`.
  - No word is lost or duplicated.
- **Reset mid-operation:** at `count` = 37, assert `rst` for 1 cycle.
  - Next cycle: `m_valid` = 0, `count` = 0, `ram_ren` = 1.
  - A following push of 32'h1 emerges first, 2 cycles later.
- **Almost flags** (`DP_FIFO_ALMOST_EN`): `almost_full` rises on the edge `count` reaches 480, and `almost_empty` falls on the edge `count` reaches 33.
